// File: rtl/issue_pair_scheduler_pkg.sv
// Shared opcode constants, instruction field/class helpers and FSM types
// for the fetch-pair issue scheduler.
package issue_pair_scheduler_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned REG_W   = 5;
  localparam int unsigned OP_W    = 7;

  localparam logic [OP_W-1:0] OP_R  = 7'b0110011;
  localparam logic [OP_W-1:0] OP_I  = 7'b0010011;
  localparam logic [OP_W-1:0] OP_LW = 7'b0000011;
  localparam logic [OP_W-1:0] OP_SW = 7'b0100011;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_SECOND = 1'b1
  } state_e;

  // Registered payload presented to decode
  typedef struct packed {
    logic [INSTR_W-1:0] instr_1;
    logic [INSTR_W-1:0] instr_2;
    logic               dual;
  } issue_t;

  function automatic logic [OP_W-1:0] opcode(input logic [INSTR_W-1:0] instr);
    return instr[6:0];
  endfunction

  function automatic logic [REG_W-1:0] rd(input logic [INSTR_W-1:0] instr);
    return instr[11:7];
  endfunction

  function automatic logic [REG_W-1:0] rs1(input logic [INSTR_W-1:0] instr);
    return instr[19:15];
  endfunction

  function automatic logic [REG_W-1:0] rs2(input logic [INSTR_W-1:0] instr);
    return instr[24:20];
  endfunction

  function automatic logic writes_rd(input logic [INSTR_W-1:0] instr);
    return (opcode(instr) == OP_R) || (opcode(instr) == OP_I) || (opcode(instr) == OP_LW);
  endfunction

  function automatic logic reads_rs1(input logic [INSTR_W-1:0] instr);
    return (opcode(instr) == OP_R) || (opcode(instr) == OP_I) ||
           (opcode(instr) == OP_LW) || (opcode(instr) == OP_SW);
  endfunction

  function automatic logic reads_rs2(input logic [INSTR_W-1:0] instr);
    return (opcode(instr) == OP_R) || (opcode(instr) == OP_SW);
  endfunction

  function automatic logic is_mem(input logic [INSTR_W-1:0] instr);
    return (opcode(instr) == OP_LW) || (opcode(instr) == OP_SW);
  endfunction

endpackage

// File: rtl/issue_pair_scheduler_hazard.sv
// Combinational intra-pair hazard check: decides whether slot 2 must
// issue a cycle after slot 1.
module pair_hazard_check
  import issue_pair_scheduler_pkg::*;
#(
  parameter bit DUAL_EN      = 1'b1,
  parameter bit SPLIT_ON_WAW = 1'b1
) (
  input  logic [INSTR_W-1:0] instr_1,
  input  logic [INSTR_W-1:0] instr_2,
  output logic               raw,
  output logic               waw,
  output logic               mem_conflict,
  output logic               split
);

  logic [REG_W-1:0] rd_1;
  logic             wr_1;

  assign rd_1 = rd(instr_1);
  assign wr_1 = writes_rd(instr_1) && (rd_1 != '0);

  // x0 as a destination never creates a dependency
  assign raw = wr_1 &&
               ((reads_rs1(instr_2) && (rs1(instr_2) == rd_1)) ||
                (reads_rs2(instr_2) && (rs2(instr_2) == rd_1)));

  assign waw = SPLIT_ON_WAW && wr_1 && writes_rd(instr_2) && (rd(instr_2) == rd_1);

  assign mem_conflict = is_mem(instr_1) && is_mem(instr_2);

  assign split = raw || waw || mem_conflict || !DUAL_EN;

endmodule

// File: rtl/issue_pair_scheduler.sv
// Fetch-pair scheduler: issues a pair together or splits it over two beats,
// through a registered valid/ready output stage.
module issue_pair_scheduler
  import issue_pair_scheduler_pkg::*;
#(
  parameter bit          DUAL_EN      = 1'b1,
  parameter bit          SPLIT_ON_WAW = 1'b1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr_1,
  input  logic [INSTR_W-1:0] in_instr_2,
  input  logic               out_ready,
  output logic               out_en_flag,
  output logic [INSTR_W-1:0] out_instr_1,
  output logic [INSTR_W-1:0] out_instr_2,
  output logic               out_dual,
  output logic [CNT_W-1:0]   split_cnt
);

  state_e             state, state_d;
  issue_t             out_q, out_d;
  logic               en_d;
  logic [INSTR_W-1:0] hold_reg, hold_d;
  logic               cnt_inc;
  logic               advance, accept;
  logic               hz_raw, hz_waw, hz_mem, hz_split, split_c;

  pair_hazard_check #(
    .DUAL_EN      (DUAL_EN),
    .SPLIT_ON_WAW (SPLIT_ON_WAW)
  ) u_hazard (
    .instr_1      (in_instr_1),
    .instr_2      (in_instr_2),
    .raw          (hz_raw),
    .waw          (hz_waw),
    .mem_conflict (hz_mem),
    .split        (hz_split)
  );

  assign split_c  = hz_split || hz_raw || hz_waw || hz_mem;
  assign advance  = out_ready || !out_en_flag;
  assign in_ready = advance && (state == ST_IDLE) && !flush;
  assign accept   = in_valid && in_ready;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state;
    if (flush) begin
      state_d = ST_IDLE;
    end else if (advance) begin
      unique case (state)
        ST_IDLE:   if (accept && (in_instr_2 != '0) && split_c) state_d = ST_SECOND;
        ST_SECOND: state_d = ST_IDLE;
      endcase
    end
  end

  // Output-stage next values; everything holds while the stage is stalled
  always_comb begin
    out_d   = out_q;
    en_d    = out_en_flag;
    hold_d  = hold_reg;
    cnt_inc = 1'b0;
    if (flush) begin
      out_d  = '0;
      en_d   = 1'b0;
      hold_d = '0;
    end else if (advance) begin
      out_d = '0;
      en_d  = 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            en_d          = 1'b1;
            out_d.instr_1 = in_instr_1;
            if (in_instr_2 != '0) begin
              if (split_c) begin
                hold_d  = in_instr_2;
                cnt_inc = 1'b1;
              end else begin
                out_d.instr_2 = in_instr_2;
                out_d.dual    = 1'b1;
              end
            end
          end
        end
        ST_SECOND: begin
          en_d          = 1'b1;
          out_d.instr_1 = hold_reg;
          hold_d        = '0;
        end
      endcase
    end
  end

  // Output, hold and counter registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q       <= '0;
      out_en_flag <= 1'b0;
      hold_reg    <= '0;
      split_cnt   <= '0;
    end else begin
      out_q       <= out_d;
      out_en_flag <= en_d;
      hold_reg    <= hold_d;
      if (cnt_inc && (split_cnt != {CNT_W{1'b1}}))
        split_cnt <= split_cnt + CNT_W'(1);
    end
  end

  assign out_instr_1 = out_q.instr_1;
  assign out_instr_2 = out_q.instr_2;
  assign out_dual    = out_q.dual;

endmodule

// File: tb/tb_issue_pair_scheduler.sv
// Directed, table-driven bench for issue_pair_scheduler with hand-written
// backpressure, flush and reset sequences.
module tb_issue_pair_scheduler;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_ready;
  logic [31:0] in_instr_1, in_instr_2, out_instr_1, out_instr_2;
  logic        out_en_flag, out_dual;
  logic [15:0] split_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  issue_pair_scheduler #(
    .DUAL_EN      (1'b1),
    .SPLIT_ON_WAW (1'b1),
    .CNT_W        (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr_1  (in_instr_1),
    .in_instr_2  (in_instr_2),
    .out_ready   (out_ready),
    .out_en_flag (out_en_flag),
    .out_instr_1 (out_instr_1),
    .out_instr_2 (out_instr_2),
    .out_dual    (out_dual),
    .split_cnt   (split_cnt)
  );

  typedef struct {
    string       tag;
    logic        rst_n, flush, in_valid, out_ready;
    logic [31:0] i1, i2;
    logic        chk_rdy, exp_rdy;
    logic        exp_en, exp_dual;
    logic [31:0] exp_o1, exp_o2;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input string tag, input logic rn, input logic fl,
                              input logic v, input logic rdy,
                              input logic [31:0] i1, input logic [31:0] i2,
                              input logic chk, input logic erdy, input logic een,
                              input logic [31:0] eo1, input logic [31:0] eo2,
                              input logic edual, input logic [15:0] ecnt);
    vec_t r;
    r.tag = tag; r.rst_n = rn; r.flush = fl; r.in_valid = v; r.out_ready = rdy;
    r.i1 = i1; r.i2 = i2; r.chk_rdy = chk; r.exp_rdy = erdy; r.exp_en = een;
    r.exp_o1 = eo1; r.exp_o2 = eo2; r.exp_dual = edual; r.exp_cnt = ecnt;
    return r;
  endfunction

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, need %h", nm, act, exp);
    end
  endtask

  // Drive one cycle (called just after a falling edge), check in_ready
  // before the rising edge and the registered outputs just after it.
  task automatic run(input vec_t v);
    rst_n      = v.rst_n;
    flush      = v.flush;
    in_valid   = v.in_valid;
    out_ready  = v.out_ready;
    in_instr_1 = v.i1;
    in_instr_2 = v.i2;
    #1;
    if (v.chk_rdy) cmp({v.tag, " in_ready"}, 32'(in_ready), 32'(v.exp_rdy));
    @(posedge clk);
    #1;
    cmp({v.tag, " en"},   32'(out_en_flag), 32'(v.exp_en));
    cmp({v.tag, " o1"},   out_instr_1, v.exp_o1);
    cmp({v.tag, " o2"},   out_instr_2, v.exp_o2);
    cmp({v.tag, " dual"}, 32'(out_dual), 32'(v.exp_dual));
    cmp({v.tag, " cnt"},  32'(split_cnt), 32'(v.exp_cnt));
    @(negedge clk);
  endtask

  localparam logic [31:0] ADD_3_1_2  = 32'h002081B3;
  localparam logic [31:0] ADDI_6_7   = 32'h00138313;
  localparam logic [31:0] ADD_5_3_4  = 32'h004182B3;
  localparam logic [31:0] LW_8       = 32'h0000A403;
  localparam logic [31:0] SW_2_9     = 32'h0024A223;
  localparam logic [31:0] ADD_X0     = 32'h00208033;
  localparam logic [31:0] ADD_5_0_4  = 32'h004002B3;
  localparam logic [31:0] ADDI_1_5   = 32'h00500093;
  localparam logic [31:0] ADDI_1_1   = 32'h00100093;
  localparam logic [31:0] ADDI_1_2   = 32'h00200093;

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr_1 = '0; in_instr_2 = '0;
    @(negedge clk);

    //           tag        rn fl v  rdy i1         i2         chk rdy en o1         o2         dual cnt
    tbl.push_back(mk("rst0",  0, 0, 0, 1, 32'h0,     32'h0,     0,  0,  0, 32'h0,     32'h0,     0,   0));
    tbl.push_back(mk("rst1",  0, 0, 1, 1, ADD_3_1_2, ADDI_6_7,  0,  0,  0, 32'h0,     32'h0,     0,   0));
    tbl.push_back(mk("indep", 1, 0, 1, 1, ADD_3_1_2, ADDI_6_7,  1,  1,  1, ADD_3_1_2, ADDI_6_7,  1,   0));
    tbl.push_back(mk("raw1",  1, 0, 1, 1, ADD_3_1_2, ADD_5_3_4, 1,  1,  1, ADD_3_1_2, 32'h0,     0,   1));
    tbl.push_back(mk("raw2",  1, 0, 1, 1, LW_8,      SW_2_9,    1,  0,  1, ADD_5_3_4, 32'h0,     0,   1));
    tbl.push_back(mk("mem1",  1, 0, 1, 1, LW_8,      SW_2_9,    1,  1,  1, LW_8,      32'h0,     0,   2));
    tbl.push_back(mk("mem2",  1, 0, 1, 1, ADD_X0,    ADD_5_0_4, 1,  0,  1, SW_2_9,    32'h0,     0,   2));
    tbl.push_back(mk("x0",    1, 0, 1, 1, ADD_X0,    ADD_5_0_4, 1,  1,  1, ADD_X0,    ADD_5_0_4, 1,   2));
    tbl.push_back(mk("empty", 1, 0, 1, 1, ADDI_1_5,  32'h0,     1,  1,  1, ADDI_1_5,  32'h0,     0,   2));
    tbl.push_back(mk("idle",  1, 0, 0, 1, 32'h0,     32'h0,     1,  1,  0, 32'h0,     32'h0,     0,   2));
    tbl.push_back(mk("waw1",  1, 0, 1, 1, ADDI_1_1,  ADDI_1_2,  1,  1,  1, ADDI_1_1,  32'h0,     0,   3));
    tbl.push_back(mk("waw2",  1, 0, 0, 1, 32'h0,     32'h0,     1,  0,  1, ADDI_1_2,  32'h0,     0,   3));
    tbl.push_back(mk("waw3",  1, 0, 0, 1, 32'h0,     32'h0,     1,  1,  0, 32'h0,     32'h0,     0,   3));
    foreach (tbl[i]) run(tbl[i]);

    // Backpressure during a split: first beat stays put, input stays blocked
    run(mk("bp_beat1", 1, 0, 1, 1, ADD_3_1_2, ADD_5_3_4, 1, 1, 1, ADD_3_1_2, 32'h0, 0, 4));
    for (int k = 0; k < 3; k++)
      run(mk("bp_stall", 1, 0, 1, 0, ADDI_6_7, 32'h0, 1, 0, 1, ADD_3_1_2, 32'h0, 0, 4));
    run(mk("bp_beat2", 1, 0, 1, 1, ADDI_6_7, 32'h0, 1, 0, 1, ADD_5_3_4, 32'h0, 0, 4));
    run(mk("bp_next",  1, 0, 1, 1, ADDI_6_7, 32'h0, 1, 1, 1, ADDI_6_7,  32'h0, 0, 4));

    // Flush while the second half is held: it must never issue
    run(mk("fl_beat1", 1, 0, 1, 1, ADD_3_1_2, ADD_5_3_4, 1, 1, 1, ADD_3_1_2, 32'h0, 0, 5));
    run(mk("fl_flush", 1, 1, 1, 1, ADD_3_1_2, ADD_5_3_4, 1, 0, 0, 32'h0, 32'h0, 0, 5));
    run(mk("fl_after", 1, 0, 0, 1, 32'h0, 32'h0, 1, 1, 0, 32'h0, 32'h0, 0, 5));

    // Reset while the second half is held: dropped and counter cleared
    run(mk("rs_beat1", 1, 0, 1, 1, LW_8, SW_2_9, 1, 1, 1, LW_8, 32'h0, 0, 6));
    run(mk("rs_reset", 0, 0, 0, 1, 32'h0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 0, 0));
    run(mk("rs_after", 1, 0, 0, 1, 32'h0, 32'h0, 1, 1, 0, 32'h0, 32'h0, 0, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
